// File: rtl/cpu_bc_port_pkg.sv
// Shared types for the MEM-stage bus port: access size codes, FSM states
// and the alignment/legality rule applied when a request is accepted.
package cpu_bc_port_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // True when the access is naturally aligned and its size exists on this bus.
    function automatic logic access_ok(input size_e size, input logic [2:0] addr_lo,
                                       input logic dword_ok);
        case (size)
            SZ_BYTE: access_ok = 1'b1;
            SZ_HALF: access_ok = (addr_lo[0] == 1'b0);
            SZ_WORD: access_ok = (addr_lo[1:0] == 2'b00);
            default: access_ok = dword_ok && (addr_lo == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/cpu_bc_port_lane_align.sv
// Combinational lane steering: byte enables, write-data replication and
// read-data shift with sign/zero extension, all for a little-endian bus.
module cpu_bc_port_lane_align
    import cpu_bc_port_pkg::*;
#(
    parameter int DW = 32,
    localparam int BW = DW / 8,
    localparam int LW = $clog2(BW)
) (
    input  size_e           size,
    input  logic [LW-1:0]   lane,
    input  logic            sign_ext,
    input  logic [DW-1:0]   wdata,
    input  logic [DW-1:0]   bus_rdata,
    output logic [BW-1:0]   be,
    output logic [DW-1:0]   lane_wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] shifted;
    logic [DW-1:0] mask;
    logic          msb;

    // Select enables/replication per size and extend the right-justified read value.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        be         = '1;
        lane_wdata = wdata;
        mask       = '1;
        shifted    = bus_rdata >> {lane, 3'b000};
        msb        = shifted[DW-1];
        case (size)
            SZ_BYTE: begin
                be         = BW'(1) << lane;
                lane_wdata = {BW{wdata[7:0]}};
                mask       = DW'(8'hFF);
                msb        = shifted[7];
            end
            SZ_HALF: begin
                be         = BW'(2'b11) << lane;
                lane_wdata = {(DW/16){wdata[15:0]}};
                mask       = DW'(16'hFFFF);
                msb        = shifted[15];
            end
            SZ_WORD: begin
                be         = BW'(4'hF) << lane;
                lane_wdata = {(DW/32){wdata[31:0]}};
                mask       = DW'(32'hFFFF_FFFF);
                msb        = shifted[31];
            end
            default: ;
        endcase
        rdata = (shifted & mask) | ({DW{sign_ext & msb}} & ~mask);
    end

endmodule

// File: rtl/cpu_bc_port.sv
// MEM-stage to bus-controller port: accepts one access at a time, checks
// alignment, runs a req/ack bus cycle with a wait-state timeout and reports
// completion or error with a one-cycle pulse.
module cpu_bc_port
    import cpu_bc_port_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [1:0]      mem_size,
    input  logic            mem_signed,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_stall,
    output logic            mem_done,
    output logic            mem_err,
    output logic            cpu_bc_req,
    output logic            cpu_bc_rw,
    output logic [AW-1:0]   cpu_bc_addr,
    output logic [DW-1:0]   cpu_bc_data,
    output logic [DW/8-1:0] cpu_bc_be,
    input  logic [DW-1:0]   bc_cpu_data,
    input  logic            bc_cpu_ack
);

    localparam int BW = DW / 8;
    localparam int LW = $clog2(BW);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e          state, state_d;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    size_e           size_q;
    logic            sign_q;
    logic [DW-1:0]   wdata_q;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rdata_q;
    logic            legal;
    logic            in_bus;
    logic [BW-1:0]   be_w;
    logic [DW-1:0]   lane_wdata;
    logic [DW-1:0]   rdata_w;

    assign legal = access_ok(size_e'(mem_size), mem_addr[2:0], DW == 64);

    cpu_bc_port_lane_align #(.DW(DW)) u_align (
        .size       (size_q),
        .lane       (addr_q[LW-1:0]),
        .sign_ext   (sign_q),
        .wdata      (wdata_q),
        .bus_rdata  (bc_cpu_data),
        .be         (be_w),
        .lane_wdata (lane_wdata),
        .rdata      (rdata_w)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Capture the accepted request so the bus sees stable values until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
        end else if (state == ST_IDLE && mem_req && legal) begin
            addr_q  <= mem_addr;
            we_q    <= mem_we;
            size_q  <= size_e'(mem_size);
            sign_q  <= mem_signed;
            wdata_q <= mem_wdata;
        end
    end

    // Wait counter: zero on entry to BUS, counts BUS cycles, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  cnt <= '0;
        else if (state != ST_BUS)                 cnt <= '0;
        else if (cnt != CNT_LAST)                 cnt <= cnt + 1'b1;
    end

    // Read result captured in the ack cycle, held for the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  rdata_q <= '0;
        else if (state == ST_BUS && bc_cpu_ack)   rdata_q <= rdata_w;
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state;
        in_bus      = (state == ST_BUS);
        mem_done    = (state == ST_DONE);
        mem_err     = (state == ST_ERR);
        mem_rdata   = rdata_q;
        cpu_bc_req  = in_bus;
        cpu_bc_rw   = in_bus & we_q;
        cpu_bc_addr = in_bus ? {addr_q[AW-1:LW], {LW{1'b0}}} : '0;
        cpu_bc_data = in_bus ? lane_wdata : '0;
        cpu_bc_be   = in_bus ? be_w : '0;
        // Stall is forced low while reset is held so the pipeline is released immediately.
        mem_stall   = ~rst & (((state == ST_IDLE) & mem_req) | in_bus);
        case (state)
            ST_IDLE: if (mem_req) state_d = legal ? ST_BUS : ST_ERR;
            ST_BUS: begin
                if (bc_cpu_ack)           state_d = ST_DONE;
                else if (cnt == CNT_LAST) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_bc_port.sv
// Directed bench for cpu_bc_port (DW=32): stimulus pushes expected responses,
// a negedge monitor pops them on every done/err pulse.
module tb_cpu_bc_port;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_size = 2'b00;
    logic          mem_signed = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_stall, mem_done, mem_err;
    logic          cpu_bc_req, cpu_bc_rw;
    logic [AW-1:0] cpu_bc_addr;
    logic [DW-1:0] cpu_bc_data;
    logic [3:0]    cpu_bc_be;
    logic [DW-1:0] bc_cpu_data = '0;
    logic          bc_cpu_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int next_id  = 0;

    typedef struct {
        int          id;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    cpu_bc_port #(.DW(DW), .AW(AW), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_size    (mem_size),
        .mem_signed  (mem_signed),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .mem_err     (mem_err),
        .cpu_bc_req  (cpu_bc_req),
        .cpu_bc_rw   (cpu_bc_rw),
        .cpu_bc_addr (cpu_bc_addr),
        .cpu_bc_data (cpu_bc_data),
        .cpu_bc_be   (cpu_bc_be),
        .bc_cpu_data (bc_cpu_data),
        .bc_cpu_ack  (bc_cpu_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (mem_done || mem_err)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pulse", {30'd0, mem_done, mem_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("resp%0d_err", e.id), 32'(mem_err), 32'(e.err));
                check($sformatf("resp%0d_done", e.id), 32'(mem_done), 32'(!e.err));
                check($sformatf("resp%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
                if (e.chk_rd) check($sformatf("resp%0d_rdata", e.id), mem_rdata, e.rdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete access; bus-side signals checked inline, response via scoreboard.
    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] bus_rd,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_baddr,
                          input logic [31:0] exp_bdata);
        exp_t e;
        e.id     = next_id++;
        e.err    = exp_err;
        e.chk_rd = !we && !exp_err;
        e.rdata  = exp_rdata;
        e.cyc    = cyc + (exp_err ? 1 : 2 + waits);
        exp_q.push_back(e);
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_signed = sgn;
        mem_addr = addr; mem_wdata = wdata;
        @(negedge clk);
        check($sformatf("acc%0d_stall_c0", e.id), 32'(mem_stall), 32'd1);
        check($sformatf("acc%0d_req_c0", e.id), 32'(cpu_bc_req), 32'd0);
        if (!exp_err) begin
            for (int i = 0; i <= waits; i++) begin
                next_cycle();
                bc_cpu_ack  = (i == waits);
                bc_cpu_data = (i == waits) ? bus_rd : ~bus_rd;
                @(negedge clk);
                check($sformatf("acc%0d_req", e.id), 32'(cpu_bc_req), 32'd1);
                check($sformatf("acc%0d_rw", e.id), 32'(cpu_bc_rw), 32'(we));
                check($sformatf("acc%0d_be", e.id), 32'(cpu_bc_be), 32'(exp_be));
                check($sformatf("acc%0d_baddr", e.id), cpu_bc_addr, exp_baddr);
                check($sformatf("acc%0d_bdata", e.id), cpu_bc_data, exp_bdata);
                check($sformatf("acc%0d_stall", e.id), 32'(mem_stall), 32'd1);
            end
        end
        next_cycle();
        bc_cpu_ack = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        check($sformatf("acc%0d_req_end", e.id), 32'(cpu_bc_req), 32'd0);
        check($sformatf("acc%0d_stall_end", e.id), 32'(mem_stall), 32'd0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int start;
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(cpu_bc_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_done_err", {30'd0, mem_done, mem_err}, 32'd0);
        check("rst_be", 32'(cpu_bc_be), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Stores and loads: we, size, signed, addr, wdata, waits, bus data,
        // err, rdata, be, bus addr, bus data.
        access(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 3, 32'h0, 0, 32'h0, 4'hF, 32'h100, 32'hDEADBEEF);
        access(0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h80000000, 0, 32'hFFFFFF80, 4'b1000, 32'h100, 32'h0);
        access(0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80000000, 0, 32'h00000080, 4'b1000, 32'h100, 32'h0);
        access(1, 2'b01, 0, 32'h202, 32'h1234, 1, 32'h0, 0, 32'h0, 4'b1100, 32'h200, 32'h12341234);
        access(1, 2'b00, 0, 32'h201, 32'hA5, 0, 32'h0, 0, 32'h0, 4'b0010, 32'h200, 32'hA5A5A5A5);
        access(0, 2'b01, 1, 32'h102, 32'h0, 2, 32'h80017777, 0, 32'hFFFF8001, 4'b1100, 32'h100, 32'h0);
        access(0, 2'b10, 0, 32'h104, 32'h0, 0, 32'h89ABCDEF, 0, 32'h89ABCDEF, 4'hF, 32'h104, 32'h0);
        access(0, 2'b01, 0, 32'h100, 32'h0, 0, 32'h1234F00D, 0, 32'h0000F00D, 4'b0011, 32'h100, 32'h0);

        // Misaligned and illegal-size accesses.
        access(0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
        access(0, 2'b11, 0, 32'h100, 32'h0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
        access(1, 2'b01, 0, 32'h203, 32'h0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0);

        // Bus timeout: 16 BUS cycles without ack, err in cycle 17.
        start    = cyc;
        e.id     = next_id++;
        e.err    = 1'b1;
        e.chk_rd = 1'b0;
        e.rdata  = 32'h0;
        e.cyc    = start + 17;
        exp_q.push_back(e);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h40;
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("to_req_c%0d", i), 32'(cpu_bc_req), 32'd1);
        end
        next_cycle();
        mem_req = 1'b0;
        @(negedge clk);
        check("to_req_dropped", 32'(cpu_bc_req), 32'd0);
        check("to_stall_low", 32'(mem_stall), 32'd0);
        // Late ack while idle must be ignored.
        next_cycle();
        bc_cpu_ack = 1'b1;
        @(negedge clk);
        check("late_ack_req", 32'(cpu_bc_req), 32'd0);
        next_cycle();
        bc_cpu_ack = 1'b0;
        repeat (2) next_cycle();

        // Reset in the middle of a bus cycle: no response expected.
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h55AA55AA;
        next_cycle();
        @(negedge clk);
        check("rstmid_req_before", 32'(cpu_bc_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_req", 32'(cpu_bc_req), 32'd0);
        check("rstmid_stall", 32'(mem_stall), 32'd0);
        check("rstmid_pulses", {30'd0, mem_done, mem_err}, 32'd0);
        mem_req = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        access(0, 2'b10, 0, 32'h108, 32'h0, 1, 32'h13579BDF, 0, 32'h13579BDF, 4'hF, 32'h108, 32'h0);

        repeat (3) next_cycle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
